// File: rtl/disp_pkg.sv
// Shared types and constants for the display scanner.
// DISP_LEADING_ZERO_BLANK_EN (optional): blank leading zeros of the shown value.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_ON   = 2'd2
    } disp_state_e;

    // The downstream decoder renders this nibble as an unlit digit.
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_scan_mux_if.sv
// Interface bundling the scanner's value-load inputs and display-side outputs.
interface disp_scan_mux_if #(
    parameter int NUM_DIGITS = 4
) ();

    // load is a one-cycle strobe with no ready: value_bcd/dp_in are taken on
    // every edge where load=1, and the scanner never back-pressures.
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_bcd;
    logic [NUM_DIGITS-1:0]     dp_in;

    logic [3:0]                digit_num;
    logic [NUM_DIGITS-1:0]     dig_an_n;
    logic                      dp_n;
    logic                      frame_tick;
    disp_pkg::disp_state_e     state_dbg;

    modport master (
        output enable, load, value_bcd, dp_in,
        input  digit_num, dig_an_n, dp_n, frame_tick, state_dbg
    );

    modport slave (
        input  enable, load, value_bcd, dp_in,
        output digit_num, dig_an_n, dp_n, frame_tick, state_dbg
    );

endinterface

// File: rtl/disp_slot_timer.sv
// Per-digit slot counter: flags the last dead cycle and the last slot cycle.
module disp_slot_timer
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic dead_done,
    output logic slot_done
);

    localparam int CNT_W = idx_width(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || slot_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dead_done = (cnt_q == CNT_W'(DEAD_CYCLES - 1));
    assign slot_done = (cnt_q == CNT_W'(REFRESH_DIV - 1));

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-segment scanner with a tear-free frame register.
// DISP_LEADING_ZERO_BLANK_EN: when defined, leading zeros are shown blank.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_mux_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    disp_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [3:0]              digit_num_q, digit_num_d;
    logic [NUM_DIGITS-1:0]   dig_an_n_q, dig_an_n_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    wrap, enter, commit;
    logic                    dead_done, slot_done, timer_clear;

`ifdef DISP_LEADING_ZERO_BLANK_EN
    function automatic logic [NUM_DIGITS-1:0] lz_blank(input logic [4*NUM_DIGITS-1:0] v);
        logic zero_above;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (v[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above;
        end
    endfunction
`endif

    assign timer_clear = (state_q == ST_IDLE) || !bus.enable;

    disp_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (timer_clear),
        .dead_done (dead_done),
        .slot_done (slot_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state; also flags the two commit points (frame wrap, scan start).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        enter   = 1'b0;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DEAD;
                    idx_d   = '0;
                    enter   = 1'b1;
                end
                ST_DEAD: begin
                    if (dead_done) state_d = ST_ON;
                end
                ST_ON: begin
                    if (slot_done) begin
                        state_d = ST_DEAD;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A load coinciding with a commit bypasses pending and lands in active.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        commit       = wrap || enter;
        if (bus.load) begin
            pend_val_d = bus.value_bcd;
            pend_dp_d  = bus.dp_in;
        end
        if (commit) begin
            pend_valid_d = 1'b0;
            if (bus.load) begin
                act_val_d = bus.value_bcd;
                act_dp_d  = bus.dp_in;
            end else if (pend_valid_q) begin
                act_val_d = pend_val_q;
                act_dp_d  = pend_dp_q;
            end
        end else if (bus.load) begin
            pend_valid_d = 1'b1;
        end
`ifdef DISP_LEADING_ZERO_BLANK_EN
        blank_d = commit ? lz_blank(act_val_d) : blank_q;
`else
        blank_d = '0;
`endif
    end

    // Outputs are decoded from next-state values so the flops line up with state_q.
    always_comb begin
        digit_num_d  = BLANK_NIBBLE;
        dig_an_n_d   = '1;
        dp_n_d       = 1'b1;
        frame_tick_d = wrap;
        if (state_d != ST_IDLE) begin
            digit_num_d = blank_d[idx_d] ? BLANK_NIBBLE : act_val_d[4*idx_d +: 4];
        end
        if (state_d == ST_ON) begin
            dig_an_n_d[idx_d] = 1'b0;
            dp_n_d            = ~act_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val_q   <= {NUM_DIGITS{BLANK_NIBBLE}};
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            act_val_q    <= {NUM_DIGITS{BLANK_NIBBLE}};
            act_dp_q     <= '0;
            blank_q      <= '0;
            digit_num_q  <= BLANK_NIBBLE;
            dig_an_n_q   <= '1;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            blank_q      <= blank_d;
            digit_num_q  <= digit_num_d;
            dig_an_n_q   <= dig_an_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.digit_num  = digit_num_q;
    assign bus.dig_an_n   = dig_an_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Self-checking bench for disp_scan_mux (4 digits, 8-cycle slots, 2 dead cycles).
module tb_disp_scan_mux;
    import disp_pkg::*;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int DC = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Slot record: {anode pattern, digit nibble, dp_n} seen at the start of an ON phase.
    logic [8:0] exp_q[$];

    disp_scan_mux_if #(.NUM_DIGITS(N)) bus ();

    disp_scan_mux #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp, input int ndig);
        logic [3:0] blank;
        logic [3:0] nib;
        logic [3:0] an;
        logic       zero_above;
        blank      = 4'b0000;
        zero_above = 1'b1;
`ifdef DISP_LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            zero_above = zero_above && (v[4*i +: 4] == 4'h0);
            blank[i]   = zero_above;
        end
`endif
        for (int i = 0; i < ndig; i++) begin
            nib    = blank[i] ? 4'hF : v[4*i +: 4];
            an     = 4'hF;
            an[i]  = 1'b0;
            exp_q.push_back({an, nib, ~dp[i]});
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] dp);
        bus.load      = 1'b1;
        bus.value_bcd = v;
        bus.dp_in     = dp;
        @(negedge clk);
        bus.load      = 1'b0;
        bus.value_bcd = $urandom_range(0, 16'hFFFF);
        bus.dp_in     = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_tick(output int t);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.frame_tick !== 1'b1 && k < 100);
        if (bus.frame_tick !== 1'b1) check_eq("tick_timeout", 32'(bus.frame_tick), 32'(1));
        t = cyc;
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_an"},    32'(bus.dig_an_n),  32'(4'hF));
        check_eq({tag, "_digit"}, 32'(bus.digit_num), 32'(4'hF));
        check_eq({tag, "_dp_n"},  32'(bus.dp_n),      32'(1));
    endtask

    // Slot monitor: pops one record per ON phase and checks its length.
    logic [3:0] prev_an = 4'hF;
    int         on_len = 0;
    always @(negedge clk) begin
        if (bus.dig_an_n != 4'hF) begin
            if (prev_an == 4'hF) begin
                if (exp_q.size() == 0) check_eq("slot_extra", 32'(exp_q.size()), 32'(1));
                else check_eq("slot", 32'({bus.dig_an_n, bus.digit_num, bus.dp_n}), 32'(exp_q.pop_front()));
                on_len <= 1;
            end else begin
                on_len <= on_len + 1;
            end
        end else if (prev_an != 4'hF && bus.enable && rst_n) begin
            check_eq("on_len", 32'(on_len), 32'(RD - DC));
        end
        prev_an <= bus.dig_an_n;
    end

    initial begin
        int t1, t2, t3, t4, t5, t6, t7, dark;
        rst_n         = 1'b1;
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.value_bcd = '0;
        bus.dp_in     = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_dark("reset");
        check_eq("reset_tick",  32'(bus.frame_tick), 32'(0));
        check_eq("reset_state", 32'(bus.state_dbg),  32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Blank scan before any load; frame period is N slots.
        push_frame(16'hFFFF, 4'b0000, 4);
        bus.enable = 1'b1;
        wait_tick(t1);
        push_frame(16'hFFFF, 4'b0000, 4);
        wait_tick(t2);
        check_eq("frame_period", 32'(t2 - t1), 32'(N * RD));

        // Mid-frame load appears only from the next frame.
        push_frame(16'hFFFF, 4'b0000, 4);
        repeat (5) @(negedge clk);
        drive_load(16'h1234, 4'b0100);
        push_frame(16'h1234, 4'b0100, 4);
        wait_tick(t3);

        repeat (12) @(negedge clk);
        drive_load(16'h5678, 4'b0001);
        push_frame(16'h5678, 4'b0001, 4);
        wait_tick(t4);

        // Load coincident with the wrap edge goes straight to the display.
        repeat (N * RD - 1) @(negedge clk);
        drive_load(16'h0009, 4'b0000);
        check_eq("tick_at_commit", 32'(bus.frame_tick), 32'(1));
        push_frame(16'h0009, 4'b0000, 2);

        // Drop enable in the middle of digit 1's ON phase.
        repeat (12) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check_dark("disable");
        check_eq("disable_state", 32'(bus.state_dbg), 32'(ST_IDLE));

        // A load while idle commits on re-entry; scan restarts at digit 0.
        drive_load(16'h4321, 4'b0001);
        repeat (3) @(negedge clk);
        push_frame(16'h4321, 4'b0001, 3);
        bus.enable = 1'b1;
        dark = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dig_an_n != 4'hF) break;
            dark++;
        end
        check_eq("dead_after_enable", 32'(dark), 32'(DC));

        // Asynchronous reset during digit 2's ON phase.
        repeat (2 * RD + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_dark("async_reset");
        check_eq("async_reset_tick", 32'(bus.frame_tick), 32'(0));
        repeat (3) @(negedge clk);
        push_frame(16'hFFFF, 4'b0000, 4);
        rst_n = 1'b1;
        wait_tick(t5);
        push_frame(16'hFFFF, 4'b0000, 4);
        repeat (6) @(negedge clk);
        drive_load(16'h0B07, 4'b1000);
        push_frame(16'h0B07, 4'b1000, 4);
        wait_tick(t6);
        wait_tick(t7);
        check_eq("frame_period_2", 32'(t7 - t6), 32'(N * RD));
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
